// File: rtl/so_pkg.sv
// Constants shared by the OS-side blocks: loader FSM encoding plus memory and HD geometry.
package so_pkg;

    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] LE_HD   = 3'd1;
    localparam logic [2:0] ESPERA  = 3'd2;
    localparam logic [2:0] ESCREVE = 3'd3;
    localparam logic [2:0] FIM     = 3'd4;
    localparam logic [2:0] FALHA   = 3'd5;

    localparam int unsigned INSTR_MEM_WORDS = 64;
    localparam int unsigned HD_TRILHAS      = 16;
    localparam int unsigned HD_SETORES      = 64;

endpackage

// File: rtl/hd_ponteiro.sv
// HD track/sector pointer: loadable, increments sector-first with wrap into the next track.
module hd_ponteiro
    import so_pkg::*;
#(
    parameter int TRILHA_W = 4,
    parameter int SETOR_W  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                inc,
    input  logic [TRILHA_W-1:0] trilha_carga,
    input  logic [SETOR_W-1:0]  setor_carga,
    output logic [TRILHA_W-1:0] trilha,
    output logic [SETOR_W-1:0]  setor,
    output logic                estouro
);

    logic setor_final;

    assign setor_final = (setor == SETOR_W'(HD_SETORES - 1));
    // High when the next increment would run past the last track of the disk.
    assign estouro     = setor_final && (trilha == TRILHA_W'(HD_TRILHAS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            trilha <= '0;
            setor  <= '0;
        end else if (load) begin
            trilha <= trilha_carga;
            setor  <= setor_carga;
        end else if (inc) begin
            if (setor_final) begin
                setor  <= '0;
                trilha <= trilha + 1'b1;
            end else begin
                setor <= setor + 1'b1;
            end
        end
    end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: copies consecutive HD words into consecutive instruction-memory addresses.
module carregador_programa
    import so_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int SETOR_W  = 6,
    parameter int TRILHA_W = 4,
    parameter int HD_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [TRILHA_W-1:0] trilha_ini,
    input  logic [SETOR_W-1:0]  setor_ini,
    input  logic [ADDR_W:0]     num_palavras,
    input  logic [ADDR_W-1:0]   end_dest_ini,
    output logic [TRILHA_W-1:0] hd_trilha,
    output logic [SETOR_W-1:0]  hd_setor,
    input  logic [DATA_W-1:0]   hd_dado,
    output logic [ADDR_W-1:0]   mi_ender,
    output logic [DATA_W-1:0]   mi_dado,
    output logic                mi_we,
    output logic                busy,
    output logic                done,
    output logic                erro
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W:0]   restante;
    logic [1:0]        espera;
    logic [7:0]        fim_dest;
    logic              carrega;
    logic              avanca;
    logic              estouro;

    assign fim_dest = 8'(end_dest_ini) + 8'(num_palavras);
    assign carrega  = (state == OCIOSO) && start && (num_palavras != '0)
                      && (fim_dest <= 8'(INSTR_MEM_WORDS));
    // The pointer only moves when another read follows, so the HD address holds after the last word.
    assign avanca   = (state == ESCREVE) && (restante != (ADDR_W+1)'(1)) && !estouro;

    hd_ponteiro #(
        .TRILHA_W (TRILHA_W),
        .SETOR_W  (SETOR_W)
    ) u_ponteiro (
        .clk          (clk),
        .reset        (reset),
        .load         (carrega),
        .inc          (avanca),
        .trilha_carga (trilha_ini),
        .setor_carga  (setor_ini),
        .trilha       (hd_trilha),
        .setor        (hd_setor),
        .estouro      (estouro)
    );

    assign busy = (state == LE_HD) || (state == ESPERA) || (state == ESCREVE);
    assign done = (state == FIM);
    assign erro = (state == FALHA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OCIOSO;
            dest     <= '0;
            restante <= '0;
            espera   <= '0;
            mi_ender <= '0;
            mi_dado  <= '0;
            mi_we    <= 1'b0;
        end else begin
            mi_we <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (start) begin
                        dest     <= end_dest_ini;
                        restante <= num_palavras;
                        if (num_palavras == '0)
                            state <= FIM;
                        else if (fim_dest > 8'(INSTR_MEM_WORDS))
                            state <= FALHA;
                        else
                            state <= LE_HD;
                    end
                end
                LE_HD: begin
                    espera <= 2'(HD_LAT - 1);
                    state  <= ESPERA;
                end
                ESPERA: begin
                    // Capture on the way into ESCREVE so the write strobe lines up with that state.
                    if (espera == '0) begin
                        mi_dado  <= hd_dado;
                        mi_ender <= dest;
                        mi_we    <= 1'b1;
                        state    <= ESCREVE;
                    end else begin
                        espera <= espera - 1'b1;
                    end
                end
                ESCREVE: begin
                    dest     <= dest + 1'b1;
                    restante <= restante - 1'b1;
                    if (restante == (ADDR_W+1)'(1))
                        state <= FIM;
                    else if (estouro)
                        state <= FALHA;
                    else
                        state <= LE_HD;
                end
                FIM, FALHA: state <= OCIOSO;
                default:    state <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: HD_LAT=1 and HD_LAT=3 instances driven from a vector table.
module tb_carregador_programa;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start3;
    logic [3:0]  tr_ini;
    logic [5:0]  se_ini;
    logic [6:0]  np;
    logic [5:0]  ed;

    logic [3:0]  hd1_t, hd3_t;
    logic [5:0]  hd1_s, hd3_s;
    logic [31:0] hd1_d, hd3_d;
    logic [5:0]  mi1_e, mi3_e;
    logic [31:0] mi1_d, mi3_d;
    logic        we1, we3, busy1, busy3, done1, done3, erro1, erro3;

    int total = 0;
    int bad   = 0;
    int wcnt1 = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] hd_word(input logic [3:0] t, input logic [5:0] s);
        return {8'hA5, 4'h0, t, 8'h3C, 2'b00, s};
    endfunction

    // HD models: data for an address appears exactly HD_LAT cycles after it is presented.
    logic [9:0] p1;
    logic [9:0] p3 [3];
    always @(posedge clk) begin
        p1    <= {hd1_t, hd1_s};
        p3[0] <= {hd3_t, hd3_s};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign hd1_d = hd_word(p1[9:6], p1[5:0]);
    assign hd3_d = hd_word(p3[2][9:6], p3[2][5:0]);

    always @(posedge clk) if (we1) wcnt1 <= wcnt1 + 1;

    carregador_programa #(.DATA_W(32), .ADDR_W(6), .SETOR_W(6), .TRILHA_W(4), .HD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .trilha_ini(tr_ini), .setor_ini(se_ini),
        .num_palavras(np), .end_dest_ini(ed), .hd_trilha(hd1_t), .hd_setor(hd1_s),
        .hd_dado(hd1_d), .mi_ender(mi1_e), .mi_dado(mi1_d), .mi_we(we1),
        .busy(busy1), .done(done1), .erro(erro1)
    );

    carregador_programa #(.DATA_W(32), .ADDR_W(6), .SETOR_W(6), .TRILHA_W(4), .HD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .trilha_ini(tr_ini), .setor_ini(se_ini),
        .num_palavras(np), .end_dest_ini(ed), .hd_trilha(hd3_t), .hd_setor(hd3_s),
        .hd_dado(hd3_d), .mi_ender(mi3_e), .mi_dado(mi3_d), .mi_we(we3),
        .busy(busy3), .done(done3), .erro(erro3)
    );

    typedef struct {
        int         sel;
        logic [3:0] t;
        logic [5:0] s;
        logic [6:0] n;
        logic [5:0] d;
        bit         ok;
        int         w;
        int         cyc;
        bit         hold;
        string      name;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int   lat, per, w, endc, busy_bad, ss, tt;
        logic got_ok, s_we, s_busy, s_done, s_erro;
        logic [5:0]  s_e;
        logic [31:0] s_d;
        lat = (v.sel != 0) ? 3 : 1;
        per = lat + 2;
        w = 0; endc = -1; busy_bad = 0; got_ok = 1'b0;
        tr_ini = v.t; se_ini = v.s; np = v.n; ed = v.d;
        if (v.sel != 0) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        if (!v.hold) begin start1 = 1'b0; start3 = 1'b0; end
        for (int c = 1; c <= 400 && endc < 0; c++) begin
            s_we   = (v.sel != 0) ? we3   : we1;
            s_busy = (v.sel != 0) ? busy3 : busy1;
            s_done = (v.sel != 0) ? done3 : done1;
            s_erro = (v.sel != 0) ? erro3 : erro1;
            s_e    = (v.sel != 0) ? mi3_e : mi1_e;
            s_d    = (v.sel != 0) ? mi3_d : mi1_d;
            if (s_we) begin
                ss = int'(v.s) + w;
                tt = int'(v.t) + ss / 64;
                chk({v.name, "_addr"}, 32'(s_e), 32'(int'(v.d) + w));
                chk({v.name, "_data"}, s_d, hd_word(4'(tt), 6'(ss % 64)));
                chk({v.name, "_wtime"}, 32'(c), 32'(per * (w + 1)));
                w++;
            end
            if (s_done || s_erro) begin
                endc   = c;
                got_ok = s_done;
                if (s_busy) busy_bad++;
            end else if (!s_busy) begin
                busy_bad++;
            end
            @(posedge clk); #1;
        end
        start1 = 1'b0; start3 = 1'b0;
        chk({v.name, "_endcyc"}, 32'(endc), 32'(v.cyc));
        chk({v.name, "_outcome"}, 32'(got_ok), 32'(v.ok));
        chk({v.name, "_nwrites"}, 32'(w), 32'(v.w));
        chk({v.name, "_busy"}, 32'(busy_bad), 32'd0);
        chk({v.name, "_pulse1"}, (v.sel != 0) ? 32'({done3, erro3}) : 32'({done1, erro1}), 32'd0);
        if (v.hold) begin
            int extra = 0;
            for (int c = 0; c < 12; c++) begin
                if (busy3 || we3) extra++;
                @(posedge clk); #1;
            end
            chk({v.name, "_norestart"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        vt[0]  = '{0, 4'd2,  6'd5,  7'd4,  6'd0,  1'b1, 4,  13,  1'b0, "basic"};
        vt[1]  = '{0, 4'd3,  6'd62, 7'd3,  6'd10, 1'b1, 3,  10,  1'b0, "wrap"};
        vt[2]  = '{0, 4'd0,  6'd0,  7'd0,  6'd5,  1'b1, 0,  1,   1'b0, "zero"};
        vt[3]  = '{0, 4'd0,  6'd0,  7'd5,  6'd60, 1'b0, 0,  1,   1'b0, "range"};
        vt[4]  = '{0, 4'd1,  6'd0,  7'd64, 6'd0,  1'b1, 64, 193, 1'b0, "full64"};
        vt[5]  = '{0, 4'd15, 6'd63, 7'd2,  6'd7,  1'b0, 1,  4,   1'b0, "trk_ovf"};
        vt[6]  = '{0, 4'd0,  6'd10, 7'd4,  6'd60, 1'b1, 4,  13,  1'b0, "edge64"};
        vt[7]  = '{0, 4'd15, 6'd62, 7'd2,  6'd40, 1'b1, 2,  7,   1'b0, "ovf_last"};
        vt[8]  = '{1, 4'd2,  6'd5,  7'd4,  6'd0,  1'b1, 4,  21,  1'b0, "lat3"};
        vt[9]  = '{1, 4'd7,  6'd63, 7'd2,  6'd30, 1'b1, 2,  11,  1'b0, "lat3_wrap"};
        vt[10] = '{1, 4'd3,  6'd7,  7'd2,  6'd5,  1'b1, 2,  11,  1'b1, "hold_start"};

        reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
        tr_ini = '0; se_ini = '0; np = '0; ed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hd_trilha", 32'(hd1_t), 32'd0);
        chk("rst_hd_setor",  32'(hd1_s), 32'd0);
        chk("rst_mi_ender",  32'(mi1_e), 32'd0);
        chk("rst_mi_dado",   mi1_d,      32'd0);
        chk("rst_flags",     32'({we1, busy1, done1, erro1}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) run_xfer(vt[i]);

        // Reset during the second ESPERA of a 4-word load.
        begin
            int snap, late;
            snap = wcnt1; late = 0;
            tr_ini = 4'd2; se_ini = 6'd5; np = 7'd4; ed = 6'd20;
            start1 = 1'b1;
            @(posedge clk); #1;
            start1 = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            chk("midrst_in_espera", 32'(busy1), 32'd1);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            chk("midrst_we",   32'(we1),   32'd0);
            chk("midrst_busy", 32'(busy1), 32'd0);
            for (int c = 0; c < 10; c++) begin
                if (done1 || erro1 || busy1) late++;
                @(posedge clk); #1;
            end
            chk("midrst_nopulse", 32'(late), 32'd0);
            chk("midrst_writes", 32'(wcnt1 - snap), 32'd1);
        end

        run_xfer(vt[0]);
        chk("hold_hd_trilha", 32'(hd1_t), 32'd2);
        chk("hold_hd_setor",  32'(hd1_s), 32'd8);
        chk("hold_mi_ender",  32'(mi1_e), 32'd3);
        chk("hold_mi_dado",   mi1_d,      hd_word(4'd2, 6'd8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/carregador_programa.md
Name: carregador_programa

Overview:
- Program loader between the simulated HD and the instruction memory (RAM).
- On a start request from OS control, it copies a block of consecutive HD words, sector by sector, into consecutive instruction-memory addresses.
- Asserts busy for the whole transfer so the OS can hold the CPU blocked.
- Sits directly upstream of the instruction memory. It drives that memory's write port, which is currently tied off.

Parameters:
- DATA_W, 32, word width of HD and instruction memory.
- ADDR_W, 6, instruction-memory address width (64 words).
- SETOR_W, 6, HD sector field width.
- TRILHA_W, 4, HD track field width.
- HD_LAT, 1, HD read latency in clk cycles from address valid to data valid; legal range 1..4.

Ports:
- clk  in  1  system clock (slow clock domain, same as the instruction-memory write clock).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle load request; sampled only in OCIOSO.
- trilha_ini  in  TRILHA_W  starting HD track.
- setor_ini  in  SETOR_W  starting HD sector.
- num_palavras  in  ADDR_W+1  words to copy, 0..64.
- end_dest_ini  in  ADDR_W  first instruction-memory address.
- hd_trilha  out  TRILHA_W  HD track address.
- hd_setor  out  SETOR_W  HD sector address.
- hd_dado  in  DATA_W  HD read data, valid HD_LAT cycles after the address.
- mi_ender  out  ADDR_W  instruction-memory write address.
- mi_dado  out  DATA_W  instruction-memory write data.
- mi_we  out  1  instruction-memory write enable.
- busy  out  1  high from the cycle after start is accepted until done/erro.
- done  out  1  one-cycle pulse at successful completion.
- erro  out  1  one-cycle pulse on a rejected or aborted transfer.

Behaviour:
- Reset: state OCIOSO. All outputs 0, including hd_trilha, hd_setor, mi_ender, mi_dado, mi_we, busy, done and erro. All internal counters are cleared.
- States: OCIOSO, LE_HD, ESPERA, ESCREVE, FIM, FALHA.
- OCIOSO, on start=1, latches all inputs and checks them:
  - num_palavras=0 -> FIM. No writes occur.
  - end_dest_ini + num_palavras > 64 (computed in 8 bits) -> FALHA. No writes occur.
  - otherwise -> LE_HD.
- LE_HD: drives hd_trilha/hd_setor with the current pointer, loads the wait counter with HD_LAT-1, then -> ESPERA. The HD address stays stable through ESPERA.
- ESPERA: decrements the wait counter. When it reaches 0 -> ESCREVE.
- ESCREVE: captures mi_dado = hd_dado and pulses mi_we=1 for exactly one cycle at mi_ender = current destination. Then:
  - increments the destination and decrements the remaining count;
  - increments the sector; on sector 63 it wraps to 0 and the track increments;
  - if the remaining count is now 0 -> FIM;
  - else if the track would overflow past 15 -> FALHA (words already written remain);
  - else -> LE_HD.
- FIM: done=1 for one cycle, busy=0 in the same cycle, then -> OCIOSO.
- FALHA: erro=1 for one cycle, busy=0 in the same cycle, then -> OCIOSO.
- busy=1 in LE_HD, ESPERA and ESCREVE.
- Throughput: HD_LAT+2 cycles per word. Total for N words is N*(HD_LAT+2) cycles from the first LE_HD; done follows one cycle after the last write.
- start while not in OCIOSO is ignored; it is not queued.
- Destination never wraps, because the range check precedes any write.
- Reset mid-transfer: the next cycle is OCIOSO with mi_we=0. Writes already done persist and no done or erro pulse is emitted.
- mi_dado and the address outputs are don't-care when mi_we=0 but must hold their last values; they do not toggle.

Decomposition:
- Shared package (so_pkg): state encoding constants; INSTR_MEM_WORDS=64; HD geometry constants (16 tracks, 64 sectors).
- Sub-module hd_ponteiro: track/sector counter with load, increment, sector wrap and track overflow flag. Reused later for the HD write path.

Test Plan:
- Basic load, HD_LAT=1: trilha_ini=2, setor_ini=5, num_palavras=4, end_dest_ini=0 -> 4 mi_we pulses at addresses 0..3 carrying HD words (2,5)..(2,8), one every 3 cycles; done 13 cycles after start; busy high for 12 cycles.
- Sector wrap: trilha_ini=3, setor_ini=62, num_palavras=3 -> reads (3,62), (3,63), (4,0); done pulse; erro never asserted.
- Rejects: num_palavras=0 -> done the cycle after start with no mi_we. end_dest_ini=60 with num_palavras=5 -> erro pulse with no mi_we; a full 64 words at end_dest_ini=0 is accepted.
- Track overflow: trilha_ini=15, setor_ini=63, num_palavras=2 -> one write (15,63) -> mem[0], then an erro pulse and no second write.
- Reset mid-op: reset asserted during the second ESPERA of a 4-word load -> mi_we=0 and busy=0 on the next cycle; mem[0] is retained; no done pulse. A subsequent start works normally.
- start held high during a transfer; HD_LAT=3 build -> only one transfer occurs, with 5 cycles per word and mi_dado equal to the HD data for the address presented 3 cycles earlier.
